dqsw_lane_training_ctrl: RTL and testbench
==========================================

# dqsw_lane_training_ctrl

Per-lane DDR3 write-leveling (DQSW) training controller. It is the fabric-side master of one lane's DQSW training IOD. It steps that IOD's dynamic delay line one tap at a time and samples the DQ feedback the DRAM returns on RX_DATA. It locates the first tap at which the sampled clock level turns from 0 to 1, then reports that tap to the PHY sequencer. One instance per byte lane sits beside the lane's IOD in the DDRPHY block.

## Interface
Parameters:
- TAP_W, 8: width of the tap counter and TAP_COUNT.
- MAX_TAPS, 255: highest tap the controller may reach; must satisfy MAX_TAPS < 2^TAP_W.
- SETTLE_CYC, 8: wait cycles after each LOAD/MOVE before sampling; must be ≥1.
- SAMPLES, 4: RX_DATA words accumulated per tap; must be ≥1.

Ports:
- FAB_CLK  in  1  sole clock; the IOD RX/TX clock domain.
- RESET  in  1  reset; synchronous, active-high.
- START  in  1  one-cycle request to begin or restart training.
- RX_DATA  in  2  DQ feedback from the IOD, both phases.
- DELAY_LINE_OUT_OF_RANGE  in  1  delay-line range flag from the IOD.
- DELAY_LINE_LOAD  out  1  one-cycle pulse that resets the delay line to its base tap.
- DELAY_LINE_MOVE  out  1  one-cycle pulse that steps the delay line one tap.
- DELAY_LINE_DIRECTION  out  1  step direction; 1 = increment.
- EYE_MONITOR_CLEAR_FLAGS  out  1  one-cycle pulse, issued together with each LOAD or MOVE.
- BUSY  out  1  high while training is in progress.
- DONE  out  1  sticky success flag.
- ERROR  out  1  sticky failure flag.
- ERR_CODE  out  2  failure cause: 0 = none, 1 = no low region found, 2 = no rising edge found, 3 = delay line out of range.
- TAP_COUNT  out  TAP_W  current tap during training; final tap once DONE or ERROR is set.

## Operation
- **FSM states:** IDLE, LOAD, SETTLE, SAMPLE, EVAL, MOVE, FIN.
- **IDLE:**
  - START=1 → LOAD.
  - Entering LOAD clears DONE, ERROR, ERR_CODE and TAP_COUNT, and sets phase to SEEK_LOW.
- **LOAD:** for exactly 1 cycle, DELAY_LINE_LOAD=1 and EYE_MONITOR_CLEAR_FLAGS=1. Then → SETTLE.
- **SETTLE:** counts SETTLE_CYC cycles, then → SAMPLE.
- **SAMPLE:**
  - Runs for SAMPLES cycles.
  - Accumulates the AND and the OR of all RX_DATA bits seen.
  - Then → EVAL.
- **EVAL classification (1 cycle):**
  - AND=1 → HIGH.
  - OR=0 → LOW.
  - Otherwise → NOISY.
- **EVAL decision:**
  - In phase SEEK_LOW, a LOW result sets phase to SEEK_HIGH.
  - In phase SEEK_HIGH, a HIGH result sets DONE=1 and → FIN. TAP_COUNT holds the current tap.
  - A NOISY result never changes phase.
  - If no decision is reached and tap == MAX_TAPS, set ERROR=1 with ERR_CODE 1 (phase SEEK_LOW) or 2 (phase SEEK_HIGH), then → FIN.
  - Otherwise → MOVE.
- **MOVE:**
  - For exactly 1 cycle, DELAY_LINE_MOVE=1, DELAY_LINE_DIRECTION=1 and EYE_MONITOR_CLEAR_FLAGS=1.
  - TAP_COUNT increments.
  - Then → SETTLE.
- **Out-of-range abort:**
  - DELAY_LINE_OUT_OF_RANGE=1 in any SETTLE or SAMPLE cycle sets ERROR=1, ERR_CODE=3, and → FIN next cycle.
  - TAP_COUNT is frozen at its current value and no further MOVE is issued.
- **FIN:**
  - BUSY=0.
  - DONE and ERROR hold until the next START or RESET.
  - START in FIN → LOAD.
- **START while busy:** START in any state other than IDLE or FIN is ignored.
- **Width rules:**
  - The tap counter never wraps; the MAX_TAPS check precedes every MOVE.
  - The SETTLE and SAMPLE counters are sized by $clog2 of their parameters.

## Timing
- **Reset:**
  - RESET=1 at a clock edge → state IDLE.
  - All outputs are 0 from that edge on, including DELAY_LINE_DIRECTION=0.
  - A MOVE or LOAD pulse in progress is truncated, and no pulse is issued after reset.
  - Reset mid-training discards the partial result.
- **BUSY:** equals 1 in LOAD, SETTLE, SAMPLE, EVAL and MOVE.
- **START to LOAD:** the edge that samples START enters LOAD, so DELAY_LINE_LOAD is high during the cycle after START.
- **Per-tap period:** 1 (LOAD/MOVE) + SETTLE_CYC + SAMPLES + 1 (EVAL) cycles.
- **Success latency:** DONE rises (T+1) × (SETTLE_CYC + SAMPLES + 2) cycles after the LOAD cycle, where T is the found tap.
- **DELAY_LINE_DIRECTION:** held at 1 from LOAD through FIN while training; 0 in IDLE.
- **Output registration:** all outputs are registered, with no combinational path from input to output.

## Structure
- **Package dqsw_training_pkg:**
  - State enum.
  - Phase enum (SEEK_LOW, SEEK_HIGH).
  - Sample-class enum (LOW, HIGH, NOISY).
  - ERR_CODE localparams ERR_NONE, ERR_NO_LOW, ERR_NO_EDGE, ERR_RANGE.
- **Sub-module dqsw_sample_classifier:**
  - Inputs: clear, RX_DATA and an enable.
  - Holds the AND/OR accumulators and outputs the class.
  - The top level owns the FSM, counters and flags.

## Test plan
All scenarios use SETTLE_CYC=4, SAMPLES=4 and MAX_TAPS=15 unless stated otherwise.
1. RX_DATA=00 on taps 0–9 and 11 from tap 10 → DONE=1, TAP_COUNT=10, exactly 10 MOVE pulses, 1 LOAD pulse, ERR_CODE=0. DONE rises 110 cycles after LOAD.
2. RX_DATA=11 on taps 0–2, 00 on taps 3–5, 11 from tap 6 → DONE, TAP_COUNT=6; the initial high region is skipped.
3. RX_DATA stuck at 11 → ERROR=1, ERR_CODE=1, TAP_COUNT=15, 15 MOVE pulses. With RX_DATA=00 throughout instead → ERR_CODE=2.
4. RX_DATA=00 on taps 0–2, alternating 01/10 on taps 3–5, 11 from tap 6 → DONE, TAP_COUNT=6.
5. DELAY_LINE_OUT_OF_RANGE asserted during tap 7 SETTLE → ERROR, ERR_CODE=3, TAP_COUNT=7, no 8th MOVE pulse. Then START → LOAD pulse and flags cleared.
6. RESET asserted mid-SAMPLE at tap 4 → all outputs 0 on the next cycle. START during BUSY is ignored. START after reset reruns from tap 0 and reproduces the result of scenario 1.

Source files
------------

// File: rtl/dqsw_training_pkg.sv
// Shared types and constants for the per-lane DQSW write-leveling controller.
// Contents: FSM state enum, search-phase enum, sample-class enum, ERR_CODE
// values and the AND/OR-to-class helper.
package dqsw_training_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SETTLE,
        S_SAMPLE,
        S_EVAL,
        S_MOVE,
        S_FIN
    } state_e;

    typedef enum logic {
        SEEK_LOW,
        SEEK_HIGH
    } phase_e;

    typedef enum logic [1:0] {
        CLS_LOW,
        CLS_HIGH,
        CLS_NOISY
    } sample_class_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_NO_LOW  = 2'd1;
    localparam logic [1:0] ERR_NO_EDGE = 2'd2;
    localparam logic [1:0] ERR_RANGE   = 2'd3;

    // All sampled bits high -> HIGH, none high -> LOW, anything else -> NOISY.
    function automatic sample_class_e classify(input logic acc_and, input logic acc_or);
        if (acc_and)      return CLS_HIGH;
        else if (!acc_or) return CLS_LOW;
        else              return CLS_NOISY;
    endfunction

endpackage

// File: rtl/dqsw_sample_classifier.sv
// Accumulates the AND and OR of every RX_DATA bit seen while enabled and
// reports the resulting sample class.
// Ports:
//   i_clk, i_reset   clock, synchronous active-high reset
//   i_clear          restart accumulation (issued on each LOAD/MOVE)
//   i_en             accumulate i_rx_data this cycle
//   i_rx_data[1:0]   DQ feedback, both phases
//   o_class_c[1:0]   sample_class_e of the accumulators (decoded from flops)
module dqsw_sample_classifier
    import dqsw_training_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic [1:0] i_rx_data,
    output logic [1:0] o_class_c
);

    logic r_acc_and;
    logic r_acc_or;

    // AND starts at 1 and OR at 0 so the first enabled word sets both directly.
    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_acc_and <= 1'b1;
            r_acc_or  <= 1'b0;
        end else if (i_en) begin
            r_acc_and <= r_acc_and & (&i_rx_data);
            r_acc_or  <= r_acc_or  | (|i_rx_data);
        end
    end

    assign o_class_c = classify(r_acc_and, r_acc_or);

endmodule

// File: rtl/dqsw_lane_training_ctrl.sv
// Per-lane DDR3 write-leveling controller: steps the lane IOD delay line one
// tap at a time, samples RX_DATA per tap and reports the first tap where the
// sampled clock turns from low to high.
// Ports:
//   i_fab_clk, i_reset              clock, synchronous active-high reset
//   i_start                         begin/restart request (IDLE or FIN only)
//   i_rx_data[1:0]                  DQ feedback
//   i_delay_line_out_of_range       IOD range flag, aborts training
//   o_delay_line_load/move          one-cycle delay-line pulses
//   o_delay_line_direction          1 = increment, high while trained/training
//   o_eye_monitor_clear_flags       pulses with every LOAD/MOVE
//   o_busy, o_done, o_error         status; DONE/ERROR sticky
//   o_err_code[1:0]                 failure cause
//   o_tap_count[TAP_W-1:0]          current / final tap
module dqsw_lane_training_ctrl
    import dqsw_training_pkg::*;
#(
    parameter int unsigned TAP_W      = 8,
    parameter int unsigned MAX_TAPS   = 255,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned SAMPLES    = 4
) (
    input  logic             i_fab_clk,
    input  logic             i_reset,
    input  logic             i_start,
    input  logic [1:0]       i_rx_data,
    input  logic             i_delay_line_out_of_range,
    output logic             o_delay_line_load,
    output logic             o_delay_line_move,
    output logic             o_delay_line_direction,
    output logic             o_eye_monitor_clear_flags,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_error,
    output logic [1:0]       o_err_code,
    output logic [TAP_W-1:0] o_tap_count
);

    localparam int unsigned SETTLE_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int unsigned SAMPLE_W = (SAMPLES > 1) ? $clog2(SAMPLES) : 1;

    state_e              r_state, w_state_nxt;
    phase_e              r_phase, w_phase_nxt;
    logic [SETTLE_W-1:0] r_settle_cnt, w_settle_cnt_nxt;
    logic [SAMPLE_W-1:0] r_sample_cnt, w_sample_cnt_nxt;
    logic [TAP_W-1:0]    r_tap, w_tap_nxt;
    logic                r_done, w_done_nxt;
    logic                r_error, w_error_nxt;
    logic [1:0]          r_err_code, w_err_code_nxt;
    logic                r_load, w_load_nxt;
    logic                r_move, w_move_nxt;
    logic                r_dir, w_dir_nxt;
    logic                r_clr, w_clr_nxt;
    logic                r_busy, w_busy_nxt;
    logic [1:0]          w_class;

    dqsw_sample_classifier u_classifier (
        .i_clk     (i_fab_clk),
        .i_reset   (i_reset),
        .i_clear   ((r_state == S_LOAD) || (r_state == S_MOVE)),
        .i_en      (r_state == S_SAMPLE),
        .i_rx_data (i_rx_data),
        .o_class_c (w_class)
    );

    // State and all output registers.
    always_ff @(posedge i_fab_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_phase      <= SEEK_LOW;
            r_settle_cnt <= '0;
            r_sample_cnt <= '0;
            r_tap        <= '0;
            r_done       <= 1'b0;
            r_error      <= 1'b0;
            r_err_code   <= ERR_NONE;
            r_load       <= 1'b0;
            r_move       <= 1'b0;
            r_dir        <= 1'b0;
            r_clr        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_phase      <= w_phase_nxt;
            r_settle_cnt <= w_settle_cnt_nxt;
            r_sample_cnt <= w_sample_cnt_nxt;
            r_tap        <= w_tap_nxt;
            r_done       <= w_done_nxt;
            r_error      <= w_error_nxt;
            r_err_code   <= w_err_code_nxt;
            r_load       <= w_load_nxt;
            r_move       <= w_move_nxt;
            r_dir        <= w_dir_nxt;
            r_clr        <= w_clr_nxt;
            r_busy       <= w_busy_nxt;
        end
    end

    // Next-state, counters and flags; outputs are decoded from the next state
    // so each one is a flop aligned with the state it belongs to.
    always_comb begin
        w_state_nxt      = r_state;
        w_phase_nxt      = r_phase;
        w_settle_cnt_nxt = r_settle_cnt;
        w_sample_cnt_nxt = r_sample_cnt;
        w_tap_nxt        = r_tap;
        w_done_nxt       = r_done;
        w_error_nxt      = r_error;
        w_err_code_nxt   = r_err_code;

        case (r_state)
            S_IDLE, S_FIN: begin
                if (i_start) begin
                    w_state_nxt    = S_LOAD;
                    w_phase_nxt    = SEEK_LOW;
                    w_tap_nxt      = '0;
                    w_done_nxt     = 1'b0;
                    w_error_nxt    = 1'b0;
                    w_err_code_nxt = ERR_NONE;
                end
            end
            S_LOAD, S_MOVE: begin
                w_state_nxt      = S_SETTLE;
                w_settle_cnt_nxt = '0;
            end
            S_SETTLE: begin
                if (i_delay_line_out_of_range) begin
                    w_state_nxt    = S_FIN;
                    w_error_nxt    = 1'b1;
                    w_err_code_nxt = ERR_RANGE;
                end else if (r_settle_cnt == SETTLE_W'(SETTLE_CYC - 1)) begin
                    w_state_nxt      = S_SAMPLE;
                    w_sample_cnt_nxt = '0;
                end else begin
                    w_settle_cnt_nxt = r_settle_cnt + SETTLE_W'(1);
                end
            end
            S_SAMPLE: begin
                if (i_delay_line_out_of_range) begin
                    w_state_nxt    = S_FIN;
                    w_error_nxt    = 1'b1;
                    w_err_code_nxt = ERR_RANGE;
                end else if (r_sample_cnt == SAMPLE_W'(SAMPLES - 1)) begin
                    w_state_nxt = S_EVAL;
                end else begin
                    w_sample_cnt_nxt = r_sample_cnt + SAMPLE_W'(1);
                end
            end
            S_EVAL: begin
                if ((r_phase == SEEK_LOW) && (w_class == CLS_LOW)) begin
                    w_phase_nxt = SEEK_HIGH;
                end
                if ((r_phase == SEEK_HIGH) && (w_class == CLS_HIGH)) begin
                    w_state_nxt = S_FIN;
                    w_done_nxt  = 1'b1;
                end else if (r_tap == TAP_W'(MAX_TAPS)) begin
                    // A low region found on the last tap still counts as found.
                    w_state_nxt    = S_FIN;
                    w_error_nxt    = 1'b1;
                    w_err_code_nxt = (w_phase_nxt == SEEK_LOW) ? ERR_NO_LOW : ERR_NO_EDGE;
                end else begin
                    w_state_nxt = S_MOVE;
                    w_tap_nxt   = r_tap + TAP_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_load_nxt = (w_state_nxt == S_LOAD);
        w_move_nxt = (w_state_nxt == S_MOVE);
        w_clr_nxt  = w_load_nxt || w_move_nxt;
        w_busy_nxt = (w_state_nxt != S_IDLE) && (w_state_nxt != S_FIN);
        w_dir_nxt  = (w_state_nxt != S_IDLE);
    end

    assign o_delay_line_load         = r_load;
    assign o_delay_line_move         = r_move;
    assign o_delay_line_direction    = r_dir;
    assign o_eye_monitor_clear_flags = r_clr;
    assign o_busy                    = r_busy;
    assign o_done                    = r_done;
    assign o_error                   = r_error;
    assign o_err_code                = r_err_code;
    assign o_tap_count               = r_tap;

endmodule

// File: tb/tb_dqsw_lane_training_ctrl.sv
// Bench for dqsw_lane_training_ctrl: table of directed tap patterns, abort and
// reset sequences, and random per-tap patterns checked against a tap-walk model.
module tb_dqsw_lane_training_ctrl;

    localparam int unsigned TAP_W      = 8;
    localparam int unsigned MAX_TAPS   = 15;
    localparam int unsigned SETTLE_CYC = 4;
    localparam int unsigned SAMPLES    = 4;
    localparam int          TAP_PERIOD = SETTLE_CYC + SAMPLES + 2;

    logic             clk = 1'b0;
    logic             i_reset, i_start, i_oor;
    logic [1:0]       i_rx;
    logic             o_load, o_move, o_dir, o_clr, o_busy, o_done, o_error;
    logic [1:0]       o_err_code;
    logic [TAP_W-1:0] o_tap;
    logic [16:0]      w_all;

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    dqsw_lane_training_ctrl #(
        .TAP_W      (TAP_W),
        .MAX_TAPS   (MAX_TAPS),
        .SETTLE_CYC (SETTLE_CYC),
        .SAMPLES    (SAMPLES)
    ) dut (
        .i_fab_clk                 (clk),
        .i_reset                   (i_reset),
        .i_start                   (i_start),
        .i_rx_data                 (i_rx),
        .i_delay_line_out_of_range (i_oor),
        .o_delay_line_load         (o_load),
        .o_delay_line_move         (o_move),
        .o_delay_line_direction    (o_dir),
        .o_eye_monitor_clear_flags (o_clr),
        .o_busy                    (o_busy),
        .o_done                    (o_done),
        .o_error                   (o_error),
        .o_err_code                (o_err_code),
        .o_tap_count               (o_tap)
    );

    assign w_all = {o_load, o_move, o_dir, o_clr, o_busy, o_done, o_error, o_err_code, o_tap};

    typedef struct {
        logic [31:0] pat;        // 2 bits per tap, tap t at [2t+1:2t]; 01 = alternate 01/10
        logic        exp_done;
        logic        exp_err;
        int          exp_code;
        int          exp_tap;
        int          exp_moves;
        int          exp_lat;    // cycles from LOAD to DONE/ERROR
    } vec_t;

    typedef struct {
        logic done, error, rst_seen, timed_out, busy_ok;
        int   code, tap, moves, loads, clrs, lat;
    } res_t;

    vec_t vecs [5];
    res_t r;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: walk taps in order, first find an all-zero tap, then an all-one tap.
    task automatic model(input logic [31:0] pat, output vec_t v);
        logic seek_low;
        logic [1:0] w;
        seek_low = 1'b1;
        v.pat = pat;
        v.exp_done = 1'b0; v.exp_err = 1'b1; v.exp_code = 0;
        v.exp_tap = int'(MAX_TAPS); v.exp_moves = int'(MAX_TAPS);
        for (int t = 0; t <= int'(MAX_TAPS); t++) begin
            w = pat[2*t +: 2];
            if (!seek_low && w == 2'b11) begin
                v.exp_done = 1'b1; v.exp_err = 1'b0;
                v.exp_tap = t; v.exp_moves = t;
                break;
            end
            if (seek_low && w == 2'b00) seek_low = 1'b0;
            if (t == int'(MAX_TAPS)) v.exp_code = seek_low ? 1 : 2;
        end
        v.exp_lat = (v.exp_tap + 1) * TAP_PERIOD;
    endtask

    // Start a run, drive RX per observed tap, stop at DONE/ERROR or injected reset.
    task automatic run_training(input logic [31:0] pat, input int oor_tap,
                                input int busy_start_tap, input int rst_tap, output res_t res);
        int tap, cyc, cyc_in_tap, load_cyc;
        logic [1:0] w;
        res.done = 0; res.error = 0; res.rst_seen = 0; res.timed_out = 1; res.busy_ok = 1;
        res.code = 0; res.tap = 0; res.moves = 0; res.loads = 0; res.clrs = 0; res.lat = 0;
        tap = 0; cyc = 0; cyc_in_tap = 0; load_cyc = 0;
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (o_load) begin
                res.loads++; load_cyc = cyc; cyc_in_tap = 0;
            end else if (o_move) begin
                res.moves++; if (tap < int'(MAX_TAPS)) tap++; cyc_in_tap = 0;
            end else begin
                cyc_in_tap++;
            end
            if (o_clr) res.clrs++;
            if (o_done || o_error) begin
                res.done = o_done; res.error = o_error; res.code = int'(o_err_code);
                res.tap = int'(o_tap); res.lat = cyc - load_cyc; res.timed_out = 0;
                break;
            end
            if (!o_busy || !o_dir) res.busy_ok = 0;
            w = pat[2*tap +: 2];
            if (w == 2'b01 && cyc[0]) w = 2'b10;
            i_rx    = w;
            i_oor   = (tap == oor_tap) && (cyc_in_tap == 1);
            i_start = (tap == busy_start_tap) && (cyc_in_tap == 3);
            if (tap == rst_tap && cyc_in_tap == 6) begin
                i_reset = 1'b1;
                tick;
                i_reset = 1'b0;
                res.rst_seen = 1; res.timed_out = 0;
                break;
            end
            tick;
            cyc++;
        end
        i_oor = 1'b0;
        i_start = 1'b0;
    endtask

    // After a finish: no pulses, not busy, flags and tap frozen.
    task automatic quiet(input string name, input int n);
        logic ok, d0, e0;
        int t0;
        d0 = o_done; e0 = o_error; t0 = int'(o_tap); ok = 1'b1;
        for (int k = 0; k < n; k++) begin
            i_rx = 2'($urandom);
            tick;
            if (o_load || o_move || o_clr || o_busy || o_done !== d0 || o_error !== e0 || int'(o_tap) != t0)
                ok = 1'b0;
        end
        chk(name, int'(ok), 1);
    endtask

    task automatic check_res(input string nm, input res_t res, input vec_t v);
        chk({nm, "_timeout"}, int'(res.timed_out), 0);
        chk({nm, "_done"}, int'(res.done), int'(v.exp_done));
        chk({nm, "_error"}, int'(res.error), int'(v.exp_err));
        chk({nm, "_code"}, res.code, v.exp_code);
        chk({nm, "_tap"}, res.tap, v.exp_tap);
        chk({nm, "_moves"}, res.moves, v.exp_moves);
        chk({nm, "_lat"}, res.lat, v.exp_lat);
    endtask

    initial begin
        vec_t v;
        logic ok;
        logic [31:0] pat;

        vecs[0] = '{32'hFFF0_0000, 1'b1, 1'b0, 0, 10, 10, 110};
        vecs[1] = '{32'hFFFF_F03F, 1'b1, 1'b0, 0,  6,  6,  70};
        vecs[2] = '{32'hFFFF_FFFF, 1'b0, 1'b1, 1, 15, 15, 160};
        vecs[3] = '{32'h0000_0000, 1'b0, 1'b1, 2, 15, 15, 160};
        vecs[4] = '{32'hFFFF_F540, 1'b1, 1'b0, 0,  6,  6,  70};

        i_reset = 1'b1; i_start = 1'b0; i_rx = 2'b00; i_oor = 1'b0;
        repeat (3) tick;
        chk("reset_outputs", int'(w_all), 0);
        i_reset = 1'b0;
        tick;
        chk("idle_outputs", int'(w_all), 0);

        for (int i = 0; i < 5; i++) begin
            run_training(vecs[i].pat, -1, -1, -1, r);
            check_res($sformatf("vec%0d", i), r, vecs[i]);
            chk($sformatf("vec%0d_loads", i), r.loads, 1);
            chk($sformatf("vec%0d_clrs", i), r.clrs, 1 + vecs[i].exp_moves);
            chk($sformatf("vec%0d_busy_dir", i), int'(r.busy_ok), 1);
            quiet($sformatf("vec%0d_quiet", i), 12);
        end

        // Out-of-range during tap 7 SETTLE.
        run_training(vecs[0].pat, 7, -1, -1, r);
        v = '{vecs[0].pat, 1'b0, 1'b1, 3, 7, 7, 72};
        check_res("oor", r, v);
        quiet("oor_no_more_move", 20);
        i_start = 1'b1;
        tick;
        i_start = 1'b0;
        chk("oor_restart_load", int'(o_load), 1);
        chk("oor_restart_clr", int'(o_clr), 1);
        chk("oor_restart_flags", int'({o_done, o_error, o_err_code}), 0);
        chk("oor_restart_busy", int'(o_busy), 1);
        i_reset = 1'b1;
        tick;
        i_reset = 1'b0;
        chk("oor_reset_outputs", int'(w_all), 0);

        // START while busy ignored, then reset mid-SAMPLE at tap 4.
        run_training(vecs[0].pat, -1, 2, 4, r);
        chk("rst_seen", int'(r.rst_seen), 1);
        chk("busy_start_ignored", r.loads, 1);
        chk("rst_moves", r.moves, 4);
        chk("rst_outputs_zero", int'(w_all), 0);
        ok = 1'b1;
        for (int k = 0; k < 15; k++) begin
            i_rx = 2'($urandom);
            tick;
            if (w_all != 17'd0) ok = 1'b0;
        end
        chk("rst_stays_zero", int'(ok), 1);
        run_training(vecs[0].pat, -1, -1, -1, r);
        check_res("rerun", r, vecs[0]);

        // Random per-tap words against the tap-walk model.
        for (int i = 0; i < 10; i++) begin
            pat = $urandom;
            model(pat, v);
            run_training(pat, -1, -1, -1, r);
            check_res($sformatf("rnd%0d", i), r, v);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
